// File: rtl/dcache_tag_lookup.sv
// dcache_tag_lookup: tag-lookup stage of the 4-way, 4-set data cache.
//
// Ports:
//   clk_i, rst_i (sync, active-high)
//   kill_i, stall_core_i: squash / hold from the pipeline
//   req_*: memory op presented to the stage
//   mem_req_o, mem_addr_o, mem_ack_i: line refill handshake
//   tl_*: values for the TL->cache pipeline latch
//   miss_stall_o: stall request to the core while a load miss refills
//
// Build option: DCACHE_PLRU_EN selects 3-bit tree pseudo-LRU.
// Without it, each set uses a 2-bit round-robin fill pointer.
module dcache_tag_lookup #(
  parameter int ADDR_W = 20,
  parameter int TAG_W  = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              kill_i,
  input  logic              stall_core_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_byte_i,
  input  logic              req_store_i,
  output logic              mem_req_o,
  output logic [ADDR_W-5:0] mem_addr_o,
  input  logic              mem_ack_i,
  output logic [ADDR_W-1:0] tl_addr_o,
  output logic              tl_rqst_byte_o,
  output logic [1:0]        tl_hit_way_o,
  output logic [1:0]        tl_lru_way_o,
  output logic              tl_miss_o,
  output logic              miss_stall_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

`ifdef DCACHE_PLRU_EN
  localparam int RW = 3;
`else
  localparam int RW = 2;
`endif

  state_t            state, state_nxt;
  logic              killed, killed_nxt;
  logic [TAG_W-1:0]  tags  [4][4];
  logic [3:0]        valid [4];
  logic [RW-1:0]     repl  [4];
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_byte;
  logic [1:0]        cap_way;

  logic [1:0]        idx, cap_idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [1:0]        hit_way;
  logic [1:0]        victim;
  logic              cap_en;
  logic              fill;

  assign idx     = req_addr_i[5:4];
  assign cap_idx = cap_addr[5:4];
  assign tag     = req_addr_i[ADDR_W-1:6];

`ifdef DCACHE_PLRU_EN
  logic hit_upd;

  // b0 picks the half (1 -> ways 2/3), b1/b2 pick inside it
  function automatic logic [1:0] victim_of(input logic [2:0] r);
    return r[0] ? {1'b1, r[2]} : {1'b0, r[1]};
  endfunction

  // point the tree away from way w
  function automatic logic [2:0] touch(input logic [2:0] r,
                                       input logic [1:0] w);
    return w[1] ? {~w[0], r[1], 1'b0} : {r[2], ~w[0], 1'b1};
  endfunction
`else
  function automatic logic [1:0] victim_of(input logic [1:0] r);
    return r;
  endfunction
`endif

  assign victim = victim_of(repl[idx]);

  // scan high to low so the lowest matching way wins
  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (req_valid_i && valid[idx][w] && tags[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    killed_nxt     = killed;
    cap_en         = 1'b0;
    fill           = 1'b0;
`ifdef DCACHE_PLRU_EN
    hit_upd        = 1'b0;
`endif
    mem_req_o      = 1'b0;
    miss_stall_o   = 1'b0;
    tl_miss_o      = 1'b0;
    tl_addr_o      = req_addr_i;
    tl_rqst_byte_o = req_byte_i;
    tl_hit_way_o   = hit_way;
    tl_lru_way_o   = victim;
    unique case (state)
      IDLE: begin
        // store miss is write-around: flag it, no allocation
        tl_miss_o = req_valid_i & ~hit & req_store_i;
`ifdef DCACHE_PLRU_EN
        hit_upd   = hit & ~stall_core_i;
`endif
        if (req_valid_i && !hit && !req_store_i && !kill_i) begin
          miss_stall_o = 1'b1;
          cap_en       = 1'b1;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        mem_req_o    = 1'b1;
        miss_stall_o = 1'b1;
        tl_hit_way_o = 2'd0;
        tl_lru_way_o = cap_way;
        killed_nxt   = killed | kill_i;
        // a kill never aborts the refill, it only skips DONE
        if (mem_ack_i) begin
          fill       = 1'b1;
          killed_nxt = 1'b0;
          state_nxt  = (killed | kill_i) ? IDLE : DONE;
        end
      end
      DONE: begin
        tl_miss_o      = 1'b1;
        tl_addr_o      = cap_addr;
        tl_rqst_byte_o = cap_byte;
        tl_hit_way_o   = cap_way;
        tl_lru_way_o   = cap_way;
        if (!stall_core_i || kill_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr_o = cap_addr[ADDR_W-1:4];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      killed   <= 1'b0;
      cap_addr <= '0;
      cap_byte <= 1'b0;
      cap_way  <= 2'd0;
      for (int s = 0; s < 4; s++) begin
        valid[s] <= 4'd0;
        repl[s]  <= '0;
      end
    end else begin
      state  <= state_nxt;
      killed <= killed_nxt;
      if (cap_en) begin
        cap_addr <= req_addr_i;
        cap_byte <= req_byte_i;
        cap_way  <= victim;
      end
      if (fill) begin
        valid[cap_idx][cap_way] <= 1'b1;
`ifdef DCACHE_PLRU_EN
        repl[cap_idx] <= touch(repl[cap_idx], cap_way);
      end else if (hit_upd) begin
        repl[idx] <= touch(repl[idx], hit_way);
`else
        repl[cap_idx] <= repl[cap_idx] + 2'd1;
`endif
      end
    end
  end

  // tag storage needs no reset; valid bits guard it
  always_ff @(posedge clk_i) begin
    if (!rst_i && fill) tags[cap_idx][cap_way] <= cap_addr[ADDR_W-1:6];
  end

endmodule

// File: tb/tb_dcache_tag_lookup.sv
// tb_dcache_tag_lookup: random + directed stimulus for dcache_tag_lookup.
// Expected outputs are queued per cycle and checked by a separate monitor.
module tb_dcache_tag_lookup;

  logic        clk = 1'b0;
  logic        rst, kill, stall_core, req_valid, req_byte, req_store;
  logic [19:0] req_addr;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr;
  logic [19:0] tl_addr;
  logic        tl_byte, tl_miss, miss_stall;
  logic [1:0]  tl_hit_way, tl_lru_way;

  always #5 clk = ~clk;

  dcache_tag_lookup dut (
    .clk_i(clk), .rst_i(rst), .kill_i(kill), .stall_core_i(stall_core),
    .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_byte_i(req_byte), .req_store_i(req_store),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack),
    .tl_addr_o(tl_addr), .tl_rqst_byte_o(tl_byte),
    .tl_hit_way_o(tl_hit_way), .tl_lru_way_o(tl_lru_way),
    .tl_miss_o(tl_miss), .miss_stall_o(miss_stall)
  );

  typedef struct {
    logic        tlchk;
    logic        mreq;
    logic [15:0] maddr;
    logic        miss;
    logic        stall;
    logic [1:0]  hw;
    logic [1:0]  lw;
    logic [19:0] ta;
    logic        tb;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // reference cache: per-set line table plus replacement bookkeeping
  logic        mv [4][4];
  logic [13:0] mt [4][4];
  int          fills [4];
  logic [2:0]  tree [4];
  logic [19:0] m_cap;

  function automatic exp_t mk(logic tc, logic mr, logic [15:0] ma,
                              logic mi, logic st, logic [1:0] hw,
                              logic [1:0] lw, logic [19:0] ta,
                              logic tb, string nm);
    exp_t e;
    e.tlchk = tc; e.mreq = mr; e.maddr = ma; e.miss = mi;
    e.stall = st; e.hw = hw; e.lw = lw; e.ta = ta; e.tb = tb;
    e.nm = nm;
    return e;
  endfunction

  task automatic cmp(string nm, string f, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0h want %0h @%0t", nm, f, act, exp,
               $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp(e.nm, "mem_req", 32'(mem_req), 32'(e.mreq));
        cmp(e.nm, "mem_addr", 32'(mem_addr), 32'(e.maddr));
        cmp(e.nm, "tl_miss", 32'(tl_miss), 32'(e.miss));
        cmp(e.nm, "stall", 32'(miss_stall), 32'(e.stall));
        if (e.tlchk) begin
          cmp(e.nm, "hit_way", 32'(tl_hit_way), 32'(e.hw));
          cmp(e.nm, "lru_way", 32'(tl_lru_way), 32'(e.lw));
          cmp(e.nm, "tl_addr", 32'(tl_addr), 32'(e.ta));
          cmp(e.nm, "tl_byte", 32'(tl_byte), 32'(e.tb));
        end
      end
    end
  end

  function automatic logic [1:0] m_victim(int s);
`ifdef DCACHE_PLRU_EN
    if (tree[s][0]) return tree[s][2] ? 2'd3 : 2'd2;
    return tree[s][1] ? 2'd1 : 2'd0;
`else
    return 2'(fills[s] % 4);
`endif
  endfunction

  task automatic m_access(int s, int w);
`ifdef DCACHE_PLRU_EN
    if (w < 2) begin
      tree[s][0] = 1'b1;
      tree[s][1] = (w == 0);
    end else begin
      tree[s][0] = 1'b0;
      tree[s][2] = (w == 2);
    end
`else
    if (s < 0 || w < 0) $display("bad model index");
`endif
  endtask

  task automatic m_reset();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 4; w++) mv[s][w] = 1'b0;
      fills[s] = 0;
      tree[s]  = 3'd0;
    end
    m_cap = 20'd0;
  endtask

  task automatic m_lookup(logic [19:0] a, output logic h,
                          output logic [1:0] w);
    h = 1'b0;
    w = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!h && mv[a[5:4]][i] && mt[a[5:4]][i] == a[19:6]) begin
        h = 1'b1;
        w = 2'(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    req_valid = 1'b0; req_addr = 20'd0; req_byte = 1'b0;
    req_store = 1'b0; kill = 1'b0; stall_core = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic idle_cycle(string nm);
    quiet();
    sbq.push_back(mk(1, 0, m_cap[19:4], 0, 0, 2'd0, m_victim(0),
                     20'd0, 0, nm));
    tick();
  endtask

  task automatic hard_reset();
    quiet();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
  endtask

  // one memory op from IDLE back to IDLE; rst_at >= 0 resets mid-REQ
  task automatic access(logic [19:0] a, logic st, logic by, int ackd,
                        int killat, int dstall, logic kidle,
                        logic score, int rst_at, string nm);
    int          s;
    logic        h, kd;
    logic [1:0]  w, v;
    s = int'(a[5:4]);
    m_lookup(a, h, w);
    v = m_victim(s);
    req_valid = 1'b1; req_addr = a; req_byte = by; req_store = st;
    kill = kidle; stall_core = score; mem_ack = 1'b0;
    if (h) begin
      sbq.push_back(mk(1, 0, m_cap[19:4], 0, 0, w, v, a, by, nm));
      tick();
      if (!score) m_access(s, int'(w));
    end else if (st || kidle) begin
      sbq.push_back(mk(1, 0, m_cap[19:4], st, 0, 2'd0, v, a, by, nm));
      tick();
    end else begin
      sbq.push_back(mk(1, 0, m_cap[19:4], 0, 1, 2'd0, v, a, by, nm));
      tick();
      m_cap = a;
      kd = 1'b0;
      req_valid = 1'b0; stall_core = 1'b1;
      for (int i = 0; i <= ackd; i++) begin
        req_addr = 20'($urandom);
        req_byte = 1'($urandom);
        kill     = (i == killat);
        mem_ack  = (i == ackd);
        rst      = (i == rst_at);
        sbq.push_back(mk(0, 1, a[19:4], 0, 1, 2'd0, 2'd0, 20'd0, 0, nm));
        tick();
        if (rst) begin
          rst = 1'b0;
          m_reset();
          quiet();
          return;
        end
        kd = kd | kill;
      end
      mt[s][v] = a[19:6];
      mv[s][v] = 1'b1;
      fills[s]++;
      m_access(s, int'(v));
      mem_ack = 1'b0; kill = 1'b0;
      if (!kd) begin
        for (int j = 0; j <= dstall; j++) begin
          stall_core = (j < dstall);
          req_addr   = 20'($urandom);
          sbq.push_back(mk(1, 0, a[19:4], 1, 0, v, v, a, by, nm));
          tick();
        end
      end
    end
    quiet();
  endtask

  function automatic logic [19:0] s1(int t);
    return 20'((t << 6) | 'h10);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ka;
    int ad;
    quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_reset();
    idle_cycle("reset");
    idle_cycle("reset2");

    access(20'h00130, 0, 0, 3, -1, 0, 0, 0, -1, "first_load");
    access(20'h00134, 0, 1, 0, -1, 0, 0, 0, -1, "first_hit");

    for (int t = 1; t <= 5; t++)
      access(s1(t), 0, 0, 1, -1, 0, 0, 0, -1, "set1_fill");
    hard_reset();
    for (int t = 1; t <= 4; t++)
      access(s1(t), 0, 0, 1, -1, 0, 0, 0, -1, "set1_refill");
    access(s1(1), 0, 0, 0, -1, 0, 0, 0, -1, "set1_rehit");
    access(s1(5), 0, 0, 1, -1, 0, 0, 0, -1, "set1_fifth");

    hard_reset();
    access(20'h00200, 1, 0, 0, -1, 0, 0, 0, -1, "store_miss");
    access(20'h00200, 0, 0, 0, -1, 0, 0, 0, -1, "store_noalloc");

    access(20'h00340, 0, 0, 2, 0, 0, 0, 0, -1, "kill_req");
    access(20'h00340, 0, 0, 0, -1, 0, 0, 0, -1, "kill_rehit");
    access(20'h00380, 0, 1, 1, 1, 0, 0, 0, -1, "kill_ack");
    access(20'h00388, 0, 0, 0, -1, 0, 0, 0, -1, "kill_ack_hit");

    access(20'h00480, 0, 0, 3, -1, 0, 0, 0, 1, "rst_mid");
    idle_cycle("rst_mid_idle");
    access(20'h00480, 0, 0, 1, -1, 0, 0, 0, -1, "rst_remiss");

    access(20'h005c0, 0, 1, 0, -1, 4, 0, 0, -1, "done_stall");

    for (int n = 0; n < 150; n++) begin
      ad = $urandom_range(0, 3);
      ka = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ad) : -1;
      access({11'd0, 3'($urandom), 2'($urandom), 4'($urandom)},
             ($urandom_range(0, 3) == 0), 1'($urandom), ad, ka,
             $urandom_range(0, 2), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 3) == 0), -1, "rand");
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
